// File: rtl/hexreader.sv
// hexreader: reads back NDIGITS active-low 7-segment patterns and decodes
// each one to its nibble once the whole bus has been unchanged for
// STABLE_CYCLES clocks. Each new stable reading is offered once on a
// valid/ready output. If a further stable reading appears while one is
// still waiting for ready, the new reading is dropped and the sticky
// overrun flag is set.
//
// Optional feature macro: HEXREADER_BLANK_EN
//   defined   -> an all-segments-off pattern (7'h7F) decodes as a legal
//                blank digit: blank bit 1, err bit 0, nibble 0.
//   undefined -> 7'h7F is an illegal glyph (err bit 1) and blank is
//                tied to 0.
module hexreader #(
  parameter int NDIGITS       = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7*NDIGITS-1:0]   seg,
  input  logic                   ready,
  output logic                   valid,
  output logic [4*NDIGITS-1:0]   data,
  output logic [NDIGITS-1:0]     err,
  output logic [NDIGITS-1:0]     blank,
  output logic                   overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Pattern {g..a} to {err, nibble}; anything outside the 16 glyphs is
  // illegal and reads as nibble 0.
  function automatic logic [4:0] decode_nib(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = {1'b0, 4'h0};
      7'h79:   r = {1'b0, 4'h1};
      7'h24:   r = {1'b0, 4'h2};
      7'h30:   r = {1'b0, 4'h3};
      7'h19:   r = {1'b0, 4'h4};
      7'h12:   r = {1'b0, 4'h5};
      7'h02:   r = {1'b0, 4'h6};
      7'h78:   r = {1'b0, 4'h7};
      7'h00:   r = {1'b0, 4'h8};
      7'h10:   r = {1'b0, 4'h9};
      7'h08:   r = {1'b0, 4'hA};
      7'h03:   r = {1'b0, 4'hB};
      7'h46:   r = {1'b0, 4'hC};
      7'h21:   r = {1'b0, 4'hD};
      7'h06:   r = {1'b0, 4'hE};
      7'h0E:   r = {1'b0, 4'hF};
`ifdef HEXREADER_BLANK_EN
      7'h7F:   r = {1'b0, 4'h0};
`endif
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  logic [7*NDIGITS-1:0] seg_q_r;
  logic [7*NDIGITS-1:0] last_r;
  logic [CW-1:0]        cnt_r;
  state_t               state_r;
  logic                 reported_r;
  logic                 valid_r;
  logic                 overrun_r;
  logic [4*NDIGITS-1:0] data_r;
  logic [NDIGITS-1:0]   err_r;
  logic [4*NDIGITS-1:0] dec_data_s;
  logic [NDIGITS-1:0]   dec_err_s;
  logic                 stable_s;

  assign stable_s = (cnt_r == CNT_MAX);

  // Decode every digit of the registered input pattern.
  always_comb begin
    dec_data_s = '0;
    dec_err_s  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      {dec_err_s[i], dec_data_s[4*i +: 4]} = decode_nib(seg_q_r[7*i +: 7]);
    end
  end

`ifdef HEXREADER_BLANK_EN
  logic [NDIGITS-1:0] dec_blank_s;
  logic [NDIGITS-1:0] blank_r;

  // Flag digits that are fully dark.
  always_comb begin
    dec_blank_s = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      dec_blank_s[i] = (seg_q_r[7*i +: 7] == 7'h7F);
    end
  end

  // Blank flags are captured together with the rest of a report.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_r <= '0;
    end else if (state_r == SETTLE && stable_s &&
                 (!reported_r || seg_q_r != last_r)) begin
      blank_r <= dec_blank_s;
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank = blank_r;
`else
  assign blank = '0;
`endif

  // Input sampling, stability counting and the report/handshake FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q_r    <= '1;
      cnt_r      <= '0;
      state_r    <= SETTLE;
      reported_r <= 1'b0;
      last_r     <= '0;
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
      data_r     <= '0;
      err_r      <= '0;
    end else begin
      seg_q_r <= seg;
      if (seg != seg_q_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      case (state_r)
        SETTLE: begin
          if (stable_s) begin
            // Compare raw patterns so distinct illegal glyphs still count
            // as a change.
            if (!reported_r || seg_q_r != last_r) begin
              data_r     <= dec_data_s;
              err_r      <= dec_err_s;
              last_r     <= seg_q_r;
              reported_r <= 1'b1;
              valid_r    <= 1'b1;
              state_r    <= REPORT;
            end else begin
              state_r <= HOLD;
            end
          end else begin
            state_r <= SETTLE;
          end
        end
        REPORT: begin
          if (ready) begin
            valid_r <= 1'b0;
            if (stable_s && seg_q_r == last_r) begin
              state_r <= HOLD;
            end else begin
              state_r <= SETTLE;
            end
          end else if (stable_s && seg_q_r != last_r) begin
            // A newer stable reading cannot be queued; it is dropped and
            // picked up again by SETTLE once the held one transfers.
            overrun_r <= 1'b1;
          end else begin
            state_r <= REPORT;
          end
        end
        HOLD: begin
          if (!stable_s) begin
            state_r <= SETTLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= SETTLE;
        end
      endcase
    end
  end

  assign valid   = valid_r;
  assign data    = data_r;
  assign err     = err_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_hexreader.sv
// Testbench for hexreader: directed scenarios followed by randomized
// patterns and ready, compared every cycle against an event-level model
// (run length of identical samples, last reported word, pending report).
module tb_hexreader;

  localparam int ND = 8;
  localparam int SC = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clk = 1'b0;
  logic            rst;
  logic [7*ND-1:0] seg;
  logic            ready;
  logic            valid;
  logic [4*ND-1:0] data;
  logic [ND-1:0]   err;
  logic [ND-1:0]   blank;
  logic            overrun;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int              run;
  logic [7*ND-1:0] last;
  logic [7*ND-1:0] rep;
  bit              has_rep;
  bit              m_valid;
  bit              m_over;
  logic [4*ND-1:0] m_data;
  logic [ND-1:0]   m_err;
  logic [ND-1:0]   m_blank;

  always #5 clk = ~clk;

  hexreader #(.NDIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .ready   (ready),
    .valid   (valid),
    .data    (data),
    .err     (err),
    .blank   (blank),
    .overrun (overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7*ND-1:0] enc(input logic [31:0] v);
    logic [7*ND-1:0] r;
    r = '0;
    for (int d = 0; d < ND; d++) r[7*d +: 7] = GLYPH[v[4*d +: 4]];
    return r;
  endfunction

  // Decode a whole word by table lookup.
  task automatic model_decode(input logic [7*ND-1:0] w);
    logic [6:0] p;
    bit found;
    for (int d = 0; d < ND; d++) begin
      p = w[7*d +: 7];
      found = 1'b0;
      m_data[4*d +: 4] = 4'h0;
      m_err[d] = 1'b0;
      m_blank[d] = 1'b0;
      for (int g = 0; g < 16; g++) begin
        if (GLYPH[g] == p) begin
          m_data[4*d +: 4] = 4'(g);
          found = 1'b1;
        end
      end
      if (!found) begin
`ifdef HEXREADER_BLANK_EN
        if (p == 7'h7F) m_blank[d] = 1'b1;
        else m_err[d] = 1'b1;
`else
        m_err[d] = 1'b1;
`endif
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_edge();
    bit st;
    if (rst) begin
      last = '1; run = 1; has_rep = 0; m_valid = 0; m_over = 0;
      m_data = '0; m_err = '0; m_blank = '0;
    end else begin
      // a pattern seen on SC+1 consecutive edges is stable from then on
      st = (run >= SC + 1);
      if (m_valid) begin
        if (ready) m_valid = 0;
        else if (st && last != rep) m_over = 1;
      end else if (st && (!has_rep || last != rep)) begin
        rep = last; has_rep = 1; m_valid = 1;
        model_decode(last);
      end
      if (seg == last) begin
        if (run < 1000) run++;
      end else begin
        run = 1;
        last = seg;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("valid", 64'(valid), 64'(m_valid));
    check("overrun", 64'(overrun), 64'(m_over));
    check("data", 64'(data), 64'(m_data));
    check("err", 64'(err), 64'(m_err));
    check("blank", 64'(blank), 64'(m_blank));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [6:0] rand_digit();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 7'h7F;
    else if (r == 1) return 7'($urandom);
    else return GLYPH[$urandom_range(0, 15)];
  endfunction

  logic [7*ND-1:0] pool [3];
  logic [7*ND-1:0] w;
  int              cnt_edges;

  initial begin
    rst = 1'b1; ready = 1'b1; seg = '1;
    tick();
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_data", 64'(data), 64'd0);
    rst = 1'b0;

    // basic report of 0x12345678: valid after the 6th edge, then quiet
    seg = enc(32'h12345678);
    cnt_edges = 0;
    while (!valid && cnt_edges < 20) begin
      tick();
      cnt_edges++;
    end
    check("first_latency", 64'(cnt_edges), 64'd6);
    check("first_data", 64'(data), 64'h12345678);
    ticks(8);

    // glitching digit 0 then settling on '1'
    w = enc(32'h12345670);
    for (int i = 0; i < 20; i++) begin
      seg = w;
      if ((i / 3) % 2 == 1) seg[6:0] = 7'h79;
      tick();
    end
    seg = enc(32'h12345671);
    ticks(10);
    check("glitch_data", 64'(data[3:0]), 64'd1);

    // overrun while the consumer stalls
    ready = 1'b0;
    seg = enc(32'hAAAAAAAA);
    ticks(8);
    seg = enc(32'hBBBBBBBB);
    ticks(10);
    check("stall_data", 64'(data), 64'hAAAAAAAA);
    check("stall_overrun", 64'(overrun), 64'd1);
    ready = 1'b1;
    ticks(10);
    check("after_stall_data", 64'(data), 64'hBBBBBBBB);

    // dark digit 3, then illegal digit 5
    w = enc(32'h87654321);
    w[27:21] = 7'h7F;
    seg = w;
    ticks(10);
    w = enc(32'h87654321);
    w[41:35] = 7'h55;
    seg = w;
    ticks(10);
    check("illegal_err", 64'(err), 64'h20);

    // reset pulse while a report is pending
    ready = 1'b0;
    seg = enc(32'hCAFE0123);
    cnt_edges = 0;
    while (!m_valid && cnt_edges < 20) begin
      tick();
      cnt_edges++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(9);
    ready = 1'b1;
    ticks(3);

    // randomized patterns, hold lengths and ready
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < ND; d++) pool[k][7*d +: 7] = rand_digit();
    end
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        seg = pool[$urandom_range(0, 2)];
      end else begin
        for (int d = 0; d < ND; d++) seg[7*d +: 7] = rand_digit();
      end
      for (int h = $urandom_range(1, 8); h > 0; h--) begin
        ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 99) == 0) rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
